// File: rtl/epl_accumulator_if.sv
// Sample-in / dump-out bus for the early-prompt-late correlator accumulator.
// The master side drives samples and out_ready; the slave side returns the dump.
interface epl_accumulator_if #(
  parameter int unsigned IN_WIDTH  = 3,
  parameter int unsigned ACC_WIDTH = 16
);
  localparam int unsigned CNT_W = 16;

  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  i_in;
  logic signed [IN_WIDTH-1:0]  q_in;
  logic                        code_early;
  logic                        code_prompt;
  logic                        code_late;
  logic                        epoch;

  logic signed [ACC_WIDTH-1:0] i_early;
  logic signed [ACC_WIDTH-1:0] q_early;
  logic signed [ACC_WIDTH-1:0] i_prompt;
  logic signed [ACC_WIDTH-1:0] q_prompt;
  logic signed [ACC_WIDTH-1:0] i_late;
  logic signed [ACC_WIDTH-1:0] q_late;
  logic [CNT_W-1:0]            dump_count;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_valid, i_in, q_in, code_early, code_prompt, code_late, epoch, out_ready,
    input  i_early, q_early, i_prompt, q_prompt, i_late, q_late, dump_count, out_valid
  );

  modport slave (
    input  in_valid, i_in, q_in, code_early, code_prompt, code_late, epoch, out_ready,
    output i_early, q_early, i_prompt, q_prompt, i_late, q_late, dump_count, out_valid
  );
endinterface

// File: rtl/epl_accumulator.sv
// Early/prompt/late I/Q integrate-and-dump over one code period, with a held dump handshake.
// Optional macro EPL_ACC_SATURATE_EN: accumulators clamp instead of wrapping.
module epl_accumulator #(
  parameter int unsigned IN_WIDTH  = 3,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_overrun,
  output logic                overrun,
  epl_accumulator_if.slave    bus
);
  localparam int unsigned PROD_W = IN_WIDTH + 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NCH    = 6;

  typedef enum logic {WAIT_EPOCH, ACCUM} state_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc     [NCH];
  logic signed [ACC_WIDTH-1:0] dump    [NCH];
  logic signed [ACC_WIDTH-1:0] prod    [NCH];
  logic signed [PROD_W-1:0]    i_ext;
  logic signed [PROD_W-1:0]    q_ext;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            dump_cnt;
  logic                        out_valid_q;
  logic                        dump_c;

`ifdef EPL_ACC_SATURATE_EN
  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  // One guard bit detects overflow; clamp to the signed range on overflow.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return s[ACC_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return a + b;
  endfunction
`endif

  // Widen by one bit first so negating the most negative sample cannot wrap.
  always_comb begin
    i_ext   = {bus.i_in[IN_WIDTH-1], bus.i_in};
    q_ext   = {bus.q_in[IN_WIDTH-1], bus.q_in};
    prod[0] = ACC_WIDTH'(bus.code_early  ? i_ext : -i_ext);
    prod[1] = ACC_WIDTH'(bus.code_early  ? q_ext : -q_ext);
    prod[2] = ACC_WIDTH'(bus.code_prompt ? i_ext : -i_ext);
    prod[3] = ACC_WIDTH'(bus.code_prompt ? q_ext : -q_ext);
    prod[4] = ACC_WIDTH'(bus.code_late   ? i_ext : -i_ext);
    prod[5] = ACC_WIDTH'(bus.code_late   ? q_ext : -q_ext);
    dump_c  = (state == ACCUM) && bus.in_valid && bus.epoch && !start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_EPOCH;
      cnt         <= '0;
      dump_cnt    <= '0;
      out_valid_q <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        acc[k]  <= '0;
        dump[k] <= '0;
      end
    end else begin
      // Re-arm drops the partial sums but leaves any held dump alone.
      if (start) begin
        state <= WAIT_EPOCH;
        cnt   <= '0;
        for (int k = 0; k < NCH; k++) acc[k] <= '0;
      end else if (bus.in_valid) begin
        case (state)
          WAIT_EPOCH: begin
            if (bus.epoch) begin
              state <= ACCUM;
              cnt   <= CNT_W'(1);
              for (int k = 0; k < NCH; k++) acc[k] <= prod[k];
            end
          end
          ACCUM: begin
            if (bus.epoch) begin
              dump_cnt <= cnt;
              cnt      <= CNT_W'(1);
              for (int k = 0; k < NCH; k++) begin
                dump[k] <= acc[k];
                acc[k]  <= prod[k];
              end
            end else begin
              cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
              for (int k = 0; k < NCH; k++) acc[k] <= acc_add(acc[k], prod[k]);
            end
          end
          default: state <= WAIT_EPOCH;
        endcase
      end

      if (dump_c) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A fresh overrun event takes priority over a clear in the same cycle.
      if (dump_c && out_valid_q && !bus.out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.i_early    = dump[0];
  assign bus.q_early    = dump[1];
  assign bus.i_prompt   = dump[2];
  assign bus.q_prompt   = dump[3];
  assign bus.i_late     = dump[4];
  assign bus.q_late     = dump[5];
  assign bus.dump_count = dump_cnt;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_epl_accumulator.sv
// Bench for epl_accumulator: 16-bit and 8-bit instances on shared stimulus,
// vector table, directed corner sequences and a randomized run against a reference model.
module tb_epl_accumulator;
  localparam int unsigned IN_W = 3;
  localparam int unsigned A16  = 16;
  localparam int unsigned A8   = 8;
`ifdef EPL_ACC_SATURATE_EN
  localparam longint SAT8 = 127;
`else
  localparam longint SAT8 = -106;
`endif

  logic clk, reset, start, clear_overrun, ovr16, ovr8;

  epl_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(A16)) bus  ();
  epl_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(A8))  bus8 ();

  assign bus8.in_valid    = bus.in_valid;
  assign bus8.i_in        = bus.i_in;
  assign bus8.q_in        = bus.q_in;
  assign bus8.code_early  = bus.code_early;
  assign bus8.code_prompt = bus.code_prompt;
  assign bus8.code_late   = bus.code_late;
  assign bus8.epoch       = bus.epoch;
  assign bus8.out_ready   = bus.out_ready;

  epl_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(A16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .clear_overrun(clear_overrun),
    .overrun(ovr16), .bus(bus));
  epl_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(A8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .clear_overrun(clear_overrun),
    .overrun(ovr8), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: per-period sums in plain integers, folded to each width.
  int     wid [2] = '{16, 8};
  longint m_acc  [2][6];
  longint m_dump [2][6];
  int     m_cnt, m_dcnt;
  bit     m_run, m_valid, m_ovr;

  function automatic longint fold(input int w, input longint v);
    longint m;
    longint r;
    m = longint'(1) << w;
`ifdef EPL_ACC_SATURATE_EN
    if (v > m / 2 - 1) return m / 2 - 1;
    if (v < -(m / 2)) return -(m / 2);
    return v;
`else
    r = v % m;
    if (r >= m / 2) r -= m;
    else if (r < -(m / 2)) r += m;
    return r;
`endif
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 6; k++) begin
        m_acc[n][k]  = 0;
        m_dump[n][k] = 0;
      end
    m_cnt = 0; m_dcnt = 0; m_run = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    longint p [6];
    longint s;
    bit     c, dump;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 6; k++) begin
      s = (k % 2 == 0) ? longint'(bus.i_in) : longint'(bus.q_in);
      c = (k / 2 == 0) ? bus.code_early : (k / 2 == 1) ? bus.code_prompt : bus.code_late;
      p[k] = c ? s : -s;
    end
    dump = 0;
    if (start) begin
      m_run = 0; m_cnt = 0;
      for (int n = 0; n < 2; n++) for (int k = 0; k < 6; k++) m_acc[n][k] = 0;
    end else if (bus.in_valid) begin
      if (bus.epoch) begin
        if (m_run) begin
          dump = 1;
          m_dcnt = m_cnt;
          for (int n = 0; n < 2; n++) for (int k = 0; k < 6; k++) m_dump[n][k] = m_acc[n][k];
        end
        m_run = 1; m_cnt = 1;
        for (int n = 0; n < 2; n++) for (int k = 0; k < 6; k++) m_acc[n][k] = p[k];
      end else if (m_run) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        for (int n = 0; n < 2; n++)
          for (int k = 0; k < 6; k++) m_acc[n][k] = fold(wid[n], m_acc[n][k] + p[k]);
      end
    end
    if (dump && m_valid && !bus.out_ready) m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    if (dump) m_valid = 1;
    else if (m_valid && bus.out_ready) m_valid = 0;
  endtask

  function automatic longint dut_out(input int n, input int k);
    if (n == 0) begin
      case (k)
        0: return longint'(bus.i_early);
        1: return longint'(bus.q_early);
        2: return longint'(bus.i_prompt);
        3: return longint'(bus.q_prompt);
        4: return longint'(bus.i_late);
        default: return longint'(bus.q_late);
      endcase
    end
    case (k)
      0: return longint'(bus8.i_early);
      1: return longint'(bus8.q_early);
      2: return longint'(bus8.i_prompt);
      3: return longint'(bus8.q_prompt);
      4: return longint'(bus8.i_late);
      default: return longint'(bus8.q_late);
    endcase
  endfunction

  function automatic longint dut_cnt(input int n);
    return (n == 0) ? longint'(bus.dump_count) : longint'(bus8.dump_count);
  endfunction
  function automatic longint dut_valid(input int n);
    return (n == 0) ? longint'(bus.out_valid) : longint'(bus8.out_valid);
  endfunction
  function automatic longint dut_ovr(input int n);
    return (n == 0) ? longint'(ovr16) : longint'(ovr8);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("%s dut%0d out%0d", tag, n, k), dut_out(n, k), m_dump[n][k]);
      check($sformatf("%s dut%0d dump_count", tag, n), dut_cnt(n), longint'(m_dcnt));
      check($sformatf("%s dut%0d out_valid", tag, n), dut_valid(n), longint'(m_valid));
      check($sformatf("%s dut%0d overrun", tag, n), dut_ovr(n), longint'(m_ovr));
    end
  endtask

  // Outputs of one instance: I taps equal ei, Q taps equal eq.
  task automatic check_iq(input string tag, input int n, input longint ei, input longint eq,
                          input longint ecnt, input longint evalid);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s out%0d", tag, k), dut_out(n, k), (k % 2 == 0) ? ei : eq);
    check($sformatf("%s dump_count", tag), dut_cnt(n), ecnt);
    check($sformatf("%s out_valid", tag), dut_valid(n), evalid);
  endtask

  task automatic set_in(input bit v, input bit ep, input int i, input int q,
                        input bit ce, input bit cp, input bit cl);
    bus.in_valid    = v;
    bus.epoch       = ep;
    bus.i_in        = IN_W'(i);
    bus.q_in        = IN_W'(q);
    bus.code_early  = ce;
    bus.code_prompt = cp;
    bus.code_late   = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic samples(input int cnt, input int i);
    for (int j = 0; j < cnt; j++) begin
      set_in(1, 0, i, 0, 1, 1, 1);
      tick();
    end
  endtask

  task automatic pulse_start();
    set_in(0, 0, 0, 0, 1, 1, 1);
    start = 1; tick(); start = 0;
  endtask

  typedef struct {
    bit st, v, ep, rdy;
    int i, q;
    int e_valid, e_cnt, e_i, e_q;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit v, input bit ep, input bit rdy,
                              input int i, input int q, input int ev, input int ec,
                              input int ei, input int eq);
    vec_t r;
    r.st = st; r.v = v; r.ep = ep; r.rdy = rdy; r.i = i; r.q = q;
    r.e_valid = ev; r.e_cnt = ec; r.e_i = ei; r.e_q = eq;
    return r;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0] = mk(1, 0, 0, 0,  0,  0, 0,  0,  0,   0);
    tbl[1] = mk(0, 1, 1, 0,  1, -2, 0,  0,  0,   0);
    for (int r = 2; r <= 10; r++) tbl[r] = mk(0, 1, 0, 0, 1, -2, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 1, 0,  1, -2, 1, 10, 10, -20);
    tbl[12] = mk(0, 0, 1, 1,  0,  0, 0, 10, 10, -20);
    tbl[13] = mk(0, 1, 0, 0, -1,  3, 0, 10, 10, -20);
    tbl[14] = mk(0, 1, 0, 0, -1,  3, 0, 10, 10, -20);
    tbl[15] = mk(0, 1, 1, 1,  2,  1, 1,  3, -1,   4);
    tbl[16] = mk(0, 0, 0, 0,  0,  0, 1,  3, -1,   4);
    tbl[17] = mk(0, 0, 0, 1,  0,  0, 0,  3, -1,   4);

    reset = 0; start = 0; clear_overrun = 0; bus.out_ready = 0;
    set_in(0, 0, 0, 0, 1, 1, 1);
    model_reset();
    tick(); tick();
    for (int n = 0; n < 2; n++) begin
      check_iq($sformatf("reset dut%0d", n), n, 0, 0, 0, 0);
      check($sformatf("reset dut%0d overrun", n), dut_ovr(n), 0);
    end
    reset = 1;
    tick();

    // Basic dump, handshake and held data from the vector table.
    for (int r = 0; r < 18; r++) begin
      start = tbl[r].st;
      bus.out_ready = tbl[r].rdy;
      set_in(tbl[r].v, tbl[r].ep, tbl[r].i, tbl[r].q, 1, 1, 1);
      tick();
      start = 0;
      check_iq($sformatf("tbl%0d", r), 0, tbl[r].e_i, tbl[r].e_q, tbl[r].e_cnt, tbl[r].e_valid);
      check($sformatf("tbl%0d overrun", r), dut_ovr(0), 0);
    end

    // Code negation of the most negative sample.
    bus.out_ready = 0;
    pulse_start();
    for (int j = 0; j < 5; j++) begin
      set_in(1, (j == 0 || j == 4), -4, 0, 1, 0, 1);
      tick();
    end
    check("neg i_prompt", dut_out(0, 2), 16);
    check("neg i_early", dut_out(0, 0), -16);
    check("neg i_late", dut_out(0, 4), -16);
    check("neg q_prompt", dut_out(0, 3), 0);
    check("neg dump_count", dut_cnt(0), 4);
    check("neg8 i_prompt", dut_out(1, 2), 16);
    set_in(0, 0, 0, 0, 1, 1, 1); bus.out_ready = 1; tick();
    check("neg drained", dut_valid(0), 0);

    // Overrun, clear, set-wins and accept-with-dump.
    bus.out_ready = 0;
    pulse_start();
    set_in(1, 1, 1, 0, 1, 1, 1); tick();
    samples(2, 1);
    set_in(1, 1, 1, 0, 1, 1, 1); tick();
    check_iq("ovr dump1", 0, 3, 0, 3, 1);
    check("ovr dump1 overrun", dut_ovr(0), 0);
    samples(1, -3);
    set_in(1, 1, 2, 0, 1, 1, 1); tick();
    check_iq("ovr dump2", 0, -2, 0, 2, 1);
    check("ovr dump2 overrun", dut_ovr(0), 1);
    set_in(0, 0, 0, 0, 1, 1, 1); tick();
    check("ovr sticky", dut_ovr(0), 1);
    clear_overrun = 1; tick(); clear_overrun = 0;
    check("ovr cleared", dut_ovr(0), 0);
    check("ovr held i_early", dut_out(0, 0), -2);
    samples(1, 1);
    set_in(1, 1, 0, 0, 1, 1, 1); clear_overrun = 1; tick();
    set_in(0, 0, 0, 0, 1, 1, 1); clear_overrun = 0;
    check("ovr set wins", dut_ovr(0), 1);
    check("ovr dump3 i_early", dut_out(0, 0), 3);
    clear_overrun = 1; tick(); clear_overrun = 0;
    samples(1, -1);
    set_in(1, 1, 0, 0, 1, 1, 1); bus.out_ready = 1; tick();
    check_iq("accept+dump", 0, -1, 0, 2, 1);
    check("accept+dump overrun", dut_ovr(0), 0);
    set_in(0, 0, 0, 0, 1, 1, 1); tick();
    check("accept drained", dut_valid(0), 0);

    // Fifty +3 samples: 150 in 16 bits, clamp or wrap in 8 bits.
    bus.out_ready = 0;
    pulse_start();
    samples(1, 3);
    set_in(1, 1, 3, 0, 1, 1, 1); tick();
    samples(49, 3);
    set_in(1, 1, 3, 0, 1, 1, 1); bus.out_ready = 1; tick();
    check_iq("sat16", 0, 150, 0, 50, 1);
    check_iq("sat8", 1, SAT8, 0, 50, 1);
    set_in(0, 0, 0, 0, 1, 1, 1); tick();

    // Asynchronous reset mid-integration, then the next epoch only arms.
    bus.out_ready = 0;
    pulse_start();
    set_in(1, 1, 1, 0, 1, 1, 1); tick();
    samples(1, 1);
    set_in(1, 1, 0, 0, 1, 1, 1); tick();
    check_iq("pre-reset dump", 0, 2, 0, 2, 1);
    samples(2, 1);
    reset = 0; #1;
    for (int n = 0; n < 2; n++) begin
      check_iq($sformatf("async reset dut%0d", n), n, 0, 0, 0, 0);
      check($sformatf("async reset dut%0d overrun", n), dut_ovr(n), 0);
    end
    tick();
    reset = 1;
    set_in(1, 1, 2, 0, 1, 1, 1); tick();
    check_iq("post-reset epoch", 0, 0, 0, 0, 0);
    samples(1, 1);
    set_in(1, 1, 0, 0, 1, 1, 1); tick();
    check_iq("post-reset dump", 0, 3, 0, 2, 1);

    // Re-arm mid-integration keeps the held dump and drops partial sums.
    samples(5, 2);
    pulse_start();
    check_iq("start holds dump", 0, 3, 0, 2, 1);
    set_in(1, 1, 1, 0, 1, 1, 1); tick();
    check_iq("rearm epoch", 0, 3, 0, 2, 1);
    check("rearm overrun", dut_ovr(0), 0);
    samples(2, -1);
    set_in(1, 1, 0, 0, 1, 1, 1); bus.out_ready = 1; tick();
    check_iq("post-start dump", 0, -1, 0, 3, 1);
    check("post-start overrun", dut_ovr(0), 0);
    set_in(0, 0, 0, 0, 1, 1, 1); tick();

    // Randomized run against the reference model, both widths.
    for (int c = 0; c < 3000; c++) begin
      start         = ($urandom_range(99) == 0);
      clear_overrun = ($urandom_range(19) == 0);
      bus.out_ready = ($urandom_range(2) == 0);
      set_in(($urandom_range(3) != 0), ($urandom_range(11) == 0),
             int'($urandom_range(7)) - 4, int'($urandom_range(7)) - 4,
             1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/epl_accumulator.md
EPL_ACCUMULATOR -- requirements
Module: epl_accumulator

Interface
REQ-001 Parameter IN_WIDTH, default 3: width of the signed two's-complement I/Q input samples after carrier wipe-off.
REQ-002 Parameter ACC_WIDTH, default 16: width of each signed accumulator and each dump output.
REQ-003 clk  input  1  single clock; every register is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; all state is cleared while reset is 0.
REQ-005 start  input  1  one-cycle pulse; arms the block, which then waits for the next code epoch.
REQ-006 in_valid  input  1  sample strobe; i_in, q_in, code and epoch inputs are sampled only when in_valid=1.
REQ-007 i_in, q_in  input  IN_WIDTH each  signed in-phase and quadrature samples.
REQ-008 code_early, code_prompt, code_late  input  1 each  C/A chips, where 1 means +1 and 0 means -1.
REQ-009 epoch  input  1  asserted with the first sample of each code period (code shift wrap).
REQ-010 i_early, q_early, i_prompt, q_prompt, i_late, q_late  output  ACC_WIDTH each  registered dump results.
REQ-011 dump_count  output  16  number of samples summed into the current dump.
REQ-012 out_valid  output  1  dump results are valid and held.
REQ-013 out_ready  input  1  consumer accepts the dump.
REQ-014 overrun  output  1  sticky flag: a dump was overwritten before it was accepted.
REQ-015 clear_overrun  input  1  clears overrun.

Function
REQ-016 The block SHALL have two states, WAIT_EPOCH and ACCUM.
REQ-017 Transitions:
- start moves any state to WAIT_EPOCH and zeroes the accumulators.
- epoch&in_valid in WAIT_EPOCH moves to ACCUM.
- ACCUM is held until start or reset.
REQ-018 Per-sample product: the sample is sign-extended to IN_WIDTH+1 bits, then negated when the code bit is 0.
- Example: -4 with code 0 gives +4 with no wrap.
REQ-019 In ACCUM, for each in_valid with epoch=0, the block SHALL add the six products (I/Q x E/P/L) to their accumulators and increment the sample counter.
REQ-020 Dump: in ACCUM, in_valid&epoch SHALL cause these actions in the same edge:
- copy the six accumulators and the sample counter into the output registers;
- load the accumulators with the current sample's products;
- set the counter to 1.
REQ-021 Latency: out_valid SHALL rise on the edge that samples the epoch, and data is visible the following cycle.
REQ-022 The epoch sample that causes the transition out of WAIT_EPOCH SHALL load the accumulators (counter=1) and SHALL NOT produce a dump.
REQ-023 In WAIT_EPOCH, in_valid without epoch SHALL be ignored, and epoch without in_valid SHALL be ignored in every state.
REQ-024 Handshake:
- out_valid stays 1 until out_valid&out_ready, then falls the next edge.
- Output registers SHALL hold stable while out_valid=1 and no new dump occurs.
REQ-025 Dump while out_valid=1 and out_ready=0: the output registers are overwritten, out_valid stays 1, and overrun is set.
REQ-026 Dump in the same cycle as an accepting out_ready: the new data loads, out_valid stays 1, and overrun is not set.
REQ-027 clear_overrun SHALL clear overrun unless an overrun event occurs in the same cycle, in which case set wins.
REQ-028 The sample counter SHALL saturate at 65535.
REQ-029 start arriving mid-integration SHALL discard the partial sums and SHALL NOT affect held output registers or out_valid.

Reset
REQ-030 When reset=0, the block SHALL reset as follows:
- state=WAIT_EPOCH;
- all accumulators, dump outputs and dump_count = 0;
- out_valid=0, overrun=0.

Configuration
REQ-031 With macro EPL_ACC_SATURATE_EN defined, each accumulator SHALL clamp at +(2^(ACC_WIDTH-1)-1) and -(2^(ACC_WIDTH-1)) instead of wrapping.
REQ-032 Without EPL_ACC_SATURATE_EN, accumulators SHALL wrap modulo 2^ACC_WIDTH, and no clamp logic is present.

Verification
REQ-033 Basic dump:
- stimulus: start, epoch, then 9 further samples with I=+1, Q=-2 and all codes 1, then epoch;
- required: i_early=i_prompt=i_late=10, q_*=-20, dump_count=10, out_valid=1.
REQ-034 Code negation:
- stimulus: all I=-4, code_prompt=0, code_early=1, 4 samples per epoch;
- required: i_prompt=+16, i_early=-16.
REQ-035 Overrun:
- stimulus: two dumps with out_ready=0 throughout;
- required: the second dump's values are presented, overrun=1; clear_overrun then gives overrun=0.
REQ-036 Saturation with ACC_WIDTH=8, I=+3, code 1, 50 samples:
- EPL_ACC_SATURATE_EN defined: i_early=127;
- not defined: i_early=150-256=-106.
REQ-037 Mid-operation events:
- reset=0 mid-integration clears all outputs asynchronously, and the next epoch produces no dump;
- start mid-integration discards 5 accumulated samples, and the next dump reflects only post-arm samples.
